perceptron_seq: RTL
===================

# perceptron_seq

Sequencer for a single-neuron perceptron datapath with a one-per-cycle multiply-accumulate. Collects an input vector over a valid/ready stream and computes a weighted sum with one shared Q3.3 fixed-point multiplier. It then thresholds the sum to a 1-bit class and, in training mode, applies the perceptron weight-update rule to its internal weight store. Sits between the input loader and the result/readout logic in the perceptron top.

## Interface

Parameters:
- N_INPUTS, 4: vector length; weights held internally, one per input.
- WIDTH, 6: data and weight width, unsigned Q3.3.
- W_INIT, 6'd8: reset value of every weight (1.0).
- ACC_W, WIDTH+$clog2(N_INPUTS): accumulator and threshold width.

Ports:
- clk: input, 1, clock.
- reset_l: input, 1, asynchronous, active-low reset.
- start: input, 1, begin an operation; sampled only in IDLE.
- train: input, 1, latched at start. 1 = train, 0 = infer.
- target: input, 1, desired class; latched at start, used only when train=1.
- abort: input, 1, synchronous return to IDLE.
- thresh: input, ACC_W, decision threshold; sampled in DECIDE.
- x_valid: input, 1, input sample valid.
- x_ready: output, 1, block accepts a sample (high only in LOAD).
- x_data: input, WIDTH, input sample.
- out_valid: output, 1, result valid (high only in DONE).
- out_ready: input, 1, consumer accepts the result.
- y: output, 1, classification result.
- acc: output, ACC_W, weighted sum.
- updated: output, 1, weights were modified by this operation.
- busy: output, 1, state is not IDLE.

## Operation

- States and transitions:
  - IDLE: on start, latch train/target, clear acc and idx, go to LOAD.
  - LOAD: x_ready=1. Each x_valid&&x_ready cycle writes x_reg[idx] and increments idx. After sample N_INPUTS-1 is taken, clear idx and go to MAC.
  - MAC: one product per cycle, acc += mul(w[idx], x_reg[idx]), idx++. Leaves after N_INPUTS cycles.
  - DECIDE: y = (acc >= thresh). If train && y != target, go to UPDATE. Otherwise go to DONE.
  - UPDATE: one weight per cycle. target=1 gives w[idx] = min(w+x, 2^WIDTH-1); target=0 gives w[idx] = max(w-x, 0). Sets updated. Goes to DONE after N_INPUTS cycles.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- mul(a,b) = (a*b)>>3 on a full 2*WIDTH product. Saturates to 2^WIDTH-1 if the result exceeds that value; no wrap.
- The acc sum cannot overflow at ACC_W, so no saturation is applied to acc.
- updated, y and acc are cleared on the start-accept edge and held stable through DONE.
- start outside IDLE is ignored.
- abort has priority over every transition and returns to IDLE next cycle. out_valid and x_ready drop. Weights already written in UPDATE are kept, with no rollback.
- Reset values: state IDLE; every weight W_INIT; x_reg, acc, idx, y and updated all 0. x_ready, out_valid and busy are all 0.

## Timing

- All state is registered. Outputs are decoded from the state register, with no combinational input-to-output paths.
- Let cycle L be the one whose edge accepts the last sample:
  - MAC runs L+1 through L+N.
  - DECIDE is L+N+1.
  - out_valid rises in cycle L+N+2, with no update.
  - With an update, UPDATE runs L+N+2 through L+2N+1 and out_valid rises in L+2N+2.
- x_valid low in LOAD stalls with no side effects. Back-pressure is unbounded.
- out_ready low holds out_valid, y, acc and updated stable.
- The earliest next start is the cycle after the out_valid&&out_ready edge.
- x_valid and start in the same IDLE cycle: the sample is not taken. x_ready becomes 1 in the next cycle.

## Structure

- Package perceptron_pkg holds:
  - the state enum (IDLE, LOAD, MAC, DECIDE, UPDATE, DONE);
  - FRAC_BITS=3;
  - Q3.3 constants ONE=6'd8 and QMAX=6'd63;
  - the saturating mul function.
- Sub-module perceptron_weight_file: N_INPUTS×WIDTH registers, async reset to W_INIT. It has a one-write port and a one-read port indexed by idx, and performs the saturating add/sub update.
- The index counter, the x_reg bank and the accumulator remain in perceptron_seq.

## Test plan

- Infer, N=4, W_INIT=8, x={8,8,8,8}, thresh=32: acc=32, y=1, updated=0. out_valid rises in cycle L+6.
- Train with target=0 on the same vector: y=1, updated=1, out_valid at L+10. All weights become 0. A following infer with thresh=1 gives acc=0 and y=0.
- Train with target=1, x={63,0,0,0}, thresh=63, weights 8: acc=63 so y=1=target, no update. Repeat with thresh=64: w[0]=min(8+63,63)=63 (saturated), other weights stay 8.
- Product saturation: x={63,63,63,63}, weights 63: each mul=63, acc=252.
- Handshakes: x_valid toggled 1-0-0-1-1-0-1 completes LOAD after exactly 4 accepts. Holding out_ready low for 5 cycles keeps out_valid, y and acc stable. start pulses while busy are ignored.
- abort asserted in UPDATE after 2 weights are written: IDLE next cycle, out_valid never rises, and w[0..1] keep their modified values. Mid-MAC reset_l low: weights return to 8 and all outputs go to 0 asynchronously.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared constants, FSM state encoding and the Q3.3 saturating multiply
// used by the perceptron sequencer.
package perceptron_pkg;

  localparam int FRAC_BITS = 3;
  localparam logic [5:0] ONE  = 6'd8;
  localparam logic [5:0] QMAX = 6'd63;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD   = 3'd1;
  localparam state_t MAC    = 3'd2;
  localparam state_t DECIDE = 3'd3;
  localparam state_t UPDATE = 3'd4;
  localparam state_t DONE   = 3'd5;

  // Full 12-bit product, drop the fraction bits, clamp instead of wrapping.
  function automatic logic [5:0] mul(input logic [5:0] a, input logic [5:0] b);
    logic [11:0] prod;
    logic [11:0] scaled;
    prod   = {6'b0, a} * {6'b0, b};
    scaled = prod >> FRAC_BITS;
    if (scaled > {6'b0, QMAX}) return QMAX;
    return scaled[5:0];
  endfunction

endpackage

// File: rtl/perceptron_weight_file.sv
// Weight store: one read and one write port sharing an index, with the
// saturating perceptron add/sub applied on write.
module perceptron_weight_file
  import perceptron_pkg::*;
#(
  parameter int               N_INPUTS = 4,
  parameter int               WIDTH    = 6,
  parameter logic [WIDTH-1:0] W_INIT   = ONE,
  parameter int               IDX_W    = 2
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic             wr_inc,
  input  logic [WIDTH-1:0] wr_x
);

  logic [WIDTH-1:0] w [N_INPUTS];
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;

  assign rd_data = w[idx];

  // NOTE: every always_comb output gets a value on every path, or a latch is inferred.
  always_comb begin
    sum = {1'b0, w[idx]} + {1'b0, wr_x};
    nxt = w[idx];
    if (wr_inc) begin
      nxt = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end else begin
      nxt = (wr_x > w[idx]) ? '0 : w[idx] - wr_x;
    end
  end

  // NOTE: the weights are flops, not RAM, so every entry is reset to a known value.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < N_INPUTS; i++) w[i] <= W_INIT;
    end else if (wr_en) begin
      // NOTE: sequential state uses non-blocking assignment to avoid read/write races.
      w[idx] <= nxt;
    end
  end

endmodule

// File: rtl/perceptron_seq.sv
// Perceptron sequencer: stream in a vector, MAC against the weight store,
// threshold to a class, and optionally apply the perceptron update.
module perceptron_seq
  import perceptron_pkg::*;
#(
  parameter int               N_INPUTS = 4,
  parameter int               WIDTH    = 6,
  parameter logic [WIDTH-1:0] W_INIT   = ONE,
  parameter int               ACC_W    = WIDTH + $clog2(N_INPUTS)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic             train,
  input  logic             target,
  input  logic             abort,
  input  logic [ACC_W-1:0] thresh,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [WIDTH-1:0] x_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic [ACC_W-1:0] acc,
  output logic             updated,
  output logic             busy
);

  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] x_reg [N_INPUTS];
  logic             train_q;
  logic             target_q;
  logic [WIDTH-1:0] w_rd;
  logic [WIDTH-1:0] prod;
  logic             last;
  logic             ge;
  logic             wr_en;

  assign x_ready   = (state == LOAD);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign last  = (idx == IDX_W'(N_INPUTS - 1));
  assign prod  = mul(w_rd, x_reg[idx]);
  assign ge    = (acc >= thresh);
  // An abort in UPDATE suppresses that cycle's write; earlier writes stay.
  assign wr_en = (state == UPDATE) && !abort;

  perceptron_weight_file #(
    .N_INPUTS(N_INPUTS),
    .WIDTH   (WIDTH),
    .W_INIT  (W_INIT),
    .IDX_W   (IDX_W)
  ) u_wfile (
    .clk    (clk),
    .reset_l(reset_l),
    .idx    (idx),
    .rd_data(w_rd),
    .wr_en  (wr_en),
    .wr_inc (target_q),
    .wr_x   (x_reg[idx])
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      y        <= 1'b0;
      updated  <= 1'b0;
      train_q  <= 1'b0;
      target_q <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) x_reg[i] <= '0;
    end else if (abort) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            train_q  <= train;
            target_q <= target;
            acc      <= '0;
            idx      <= '0;
            y        <= 1'b0;
            updated  <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (x_valid) begin
            x_reg[idx] <= x_data;
            if (last) begin
              idx   <= '0;
              state <= MAC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (last) begin
            idx   <= '0;
            state <= DECIDE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DECIDE: begin
          y     <= ge;
          idx   <= '0;
          state <= (train_q && (ge != target_q)) ? UPDATE : DONE;
        end
        UPDATE: begin
          updated <= 1'b1;
          if (last) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
